// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch channel: req/addr held until a single-cycle ack returns rdata.
interface pc_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              ce;

  modport master (output imem_req, imem_addr, ce, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, ce, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch PC generator with req/ack memory handshake, branch/flush redirect, IF stall and a
// one-entry skid buffer that catches a returning instruction while IF/ID is stalled.
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       PC_STEP      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  pc_fetch_if.master        imem,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN, S_SKID} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ce_q;
  logic              vld_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] skid_pc_q;
  logic [DATA_W-1:0] skid_inst_q;

  logic              redirect_d;
  logic [ADDR_W-1:0] target_d;
  logic [ADDR_W-1:0] pc_next_d;
  logic              vld_hold_d;
  logic              take_d;

  always_comb begin
    redirect_d = flush | branch_flag;
    target_d   = flush ? flush_pc : branch_target;
    pc_next_d  = pc_q + ADDR_W'(PC_STEP);
    // The delivered instruction survives only while IF/ID stalls and no flush kills it.
    vld_hold_d = vld_q & stall_if & ~flush;
    take_d     = ~vld_q | ~stall_if;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_VECTOR;
      req_q       <= 1'b0;
      addr_q      <= '0;
      ce_q        <= 1'b0;
      vld_q       <= 1'b0;
      if_pc_q     <= '0;
      inst_q      <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      ce_q  <= 1'b1;
      vld_q <= vld_hold_d;
      unique case (state_q)
        S_BOOT: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          addr_q  <= redirect_d ? target_d : pc_q;
          pc_q    <= redirect_d ? target_d : pc_q;
        end
        S_FETCH: begin
          if (redirect_d) begin
            pc_q <= target_d;
            // An ack this cycle closes the old request, so the new one can go out at once.
            if (imem.imem_ack) addr_q  <= target_d;
            else               state_q <= S_DRAIN;
          end else if (imem.imem_ack) begin
            pc_q <= pc_next_d;
            if (take_d) begin
              vld_q   <= 1'b1;
              if_pc_q <= addr_q;
              inst_q  <= imem.imem_rdata;
              addr_q  <= pc_next_d;
            end else begin
              skid_pc_q   <= addr_q;
              skid_inst_q <= imem.imem_rdata;
              req_q       <= 1'b0;
              state_q     <= S_SKID;
            end
          end
        end
        S_DRAIN: begin
          if (redirect_d) pc_q <= target_d;
          if (imem.imem_ack) begin
            addr_q  <= redirect_d ? target_d : pc_q;
            state_q <= S_FETCH;
          end
        end
        S_SKID: begin
          if (redirect_d) begin
            pc_q    <= target_d;
            req_q   <= 1'b1;
            addr_q  <= target_d;
            state_q <= S_FETCH;
          end else if (!stall_if) begin
            vld_q   <= 1'b1;
            if_pc_q <= skid_pc_q;
            inst_q  <= skid_inst_q;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign imem.ce        = ce_q;
  assign if_valid       = vld_q;
  assign if_pc          = if_pc_q;
  assign if_inst        = inst_q;

endmodule
